mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single main data memory port between two cache controllers: requester 0 (instruction side) and requester 1 (data side).
- Each requester issues either a 128-bit line refill read or a 32-bit word write-through. The arbiter serialises these, drives the memory's read/write enables, waits for the memory ready handshake, and returns the line plus a one-cycle acknowledge.
- Sits between the cache controllers and data memory at integration level.

Parameters:
- ADDR_W, 10, byte/word address width passed to memory
- WORD_W, 32, write data width
- LINE_W, 128, refill line width
- TIMEOUT, 255, max cycles waiting for mem_ready (used only with MEM_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- r0_req  in  1  requester 0 request, level, held until r0_ack
- r0_we  in  1  1 = word write, 0 = line read
- r0_addr  in  ADDR_W  access address
- r0_wdata  in  WORD_W  write data
- r0_ack  out  1  one-cycle completion pulse
- r1_req, r1_we, r1_addr, r1_wdata, r1_ack  same as r0_*, for requester 1
- rdata  out  LINE_W  read line, valid when either ack is high
- err  out  1  access aborted, valid with ack (0 unless MEM_ARB_TIMEOUT_EN)
- mem_read_en  out  1  memory read enable
- mem_write_en  out  1  memory write enable
- mem_addr  out  ADDR_W  latched address to memory
- mem_wdata  out  WORD_W  latched write data to memory
- mem_ready  in  1  memory done; line valid on mem_rdata this cycle
- mem_rdata  in  LINE_W  memory read line
- grant  out  2  one-hot owner, 00 when IDLE
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0, including rdata, mem_addr, mem_wdata, grant, ack and err. last_grant=0. Any access in flight is dropped immediately and enables fall without waiting for a clock.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - No req: stay.
  - Any req: choose the winner, latch its addr/we/wdata into mem_addr/mem_wdata and an internal we flag, set grant, go to ACCESS.
- Arbitration: round-robin.
  - Single requester wins outright.
  - Both requesting: the requester not equal to last_grant wins.
  - last_grant is updated on entry to RESP.
  - After reset (last_grant=0), requester 1 wins the first tie.
- ACCESS:
  - mem_read_en = ~we, mem_write_en = we, held continuously.
  - mem_addr and mem_wdata are stable for the whole state.
  - mem_ready=1: capture mem_rdata into rdata (write: rdata captured but don't-care), go to RESP. Enables drop the cycle after mem_ready is sampled.
  - mem_ready=0: stay.
- RESP: ack for the granted requester high for exactly 1 cycle; rdata held; grant still valid; go to IDLE.
- Requester rule: must keep req/addr/we/wdata stable from assertion until ack. Requester deasserts req in the cycle after ack (registered). The arbiter does not re-sample req during ACCESS/RESP.
- Latency: req seen in IDLE cycle T; enables high from T+1; mem_ready in cycle T+k (k≥1); ack in T+k+1; earliest next grant T+k+2. Minimum 3 cycles per access.
- rdata holds its last value until the next RESP (or reset).
- mem_ready while IDLE: ignored.
- Requester changing request mid-access: not required to be handled; the latched values are used.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - An 8+-bit counter (ceil log2(TIMEOUT+1) bits) clears on entering ACCESS and increments each ACCESS cycle without mem_ready.
  - When the count reaches TIMEOUT: enables drop, go to RESP with err=1 and rdata=0. last_grant is still updated.
  - mem_ready on the same cycle as the limit wins: normal completion, err=0.
- Undefined: no counter; ACCESS waits indefinitely; err tied 0.

Test Plan:
- Reset mid-access: r0 read in ACCESS, pull rst low -> mem_read_en=0 the same cycle, grant=00, busy=0, no ack after release.
- Single read: r0_req=1, we=0, addr=0x040; mem_ready asserted 4 cycles after mem_read_en rises with mem_rdata=0xDEADBEEF_01234567_89ABCDEF_CAFEF00D -> r0_ack one pulse, rdata equal to that value, r1_ack never high.
- Single write: r1 we=1, addr=0x3FC, wdata=0x12345678 -> mem_write_en=1, mem_addr=0x3FC, mem_wdata=0x12345678 held until mem_ready; r1_ack one cycle later; mem_read_en never high.
- Tie after reset: r0_req and r1_req both asserted in the same cycle -> r1 granted first, then r0. Repeat the tie -> strict alternation r1, r0, r1, r0, no starvation.
- Back-to-back: r0 re-requests the cycle after its ack while r1 waits -> r1 granted next.
- MEM_ARB_TIMEOUT_EN with TIMEOUT=8: mem_ready held low -> after 8 ACCESS cycles, r0_ack=1, err=1, rdata=0. A following access with a prompt ready completes with err=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between an instruction-side and a data-side cache controller.
// Optional access timeout is compiled in with `define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int WORD_W  = 32,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [WORD_W-1:0] r0_wdata,
  output logic              r0_ack,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [WORD_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [LINE_W-1:0] rdata,
  output logic              err,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic [1:0]        grant,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q;
  logic                last_grant_q;
  logic                we_q;
  logic [1:0]          grant_q;
  logic                r0_ack_q;
  logic                r1_ack_q;
  logic                rd_en_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WORD_W-1:0]   wdata_q;
  logic [LINE_W-1:0]   rdata_q;
  logic                pick1;

  // On a tie the requester that did not win last time goes next.
  assign pick1 = r1_req & (~r0_req | ~last_grant_q);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      we_q         <= 1'b0;
      grant_q      <= 2'b00;
      r0_ack_q     <= 1'b0;
      r1_ack_q     <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      r0_ack_q <= 1'b0;
      r1_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (r0_req || r1_req) begin
            grant_q <= pick1 ? 2'b10 : 2'b01;
            addr_q  <= pick1 ? r1_addr  : r0_addr;
            wdata_q <= pick1 ? r1_wdata : r0_wdata;
            we_q    <= pick1 ? r1_we    : r0_we;
            rd_en_q <= pick1 ? ~r1_we   : ~r0_we;
            wr_en_q <= pick1 ? r1_we    : r0_we;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          // A ready arriving on the limit cycle still completes normally.
          if (mem_ready) begin
            rdata_q      <= mem_rdata;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            r0_ack_q     <= grant_q[0];
            r1_ack_q     <= grant_q[1];
            last_grant_q <= grant_q[1];
            state_q      <= RESP;
`ifdef MEM_ARB_TIMEOUT_EN
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            rdata_q      <= '0;
            err_q        <= 1'b1;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            r0_ack_q     <= grant_q[0];
            r1_ack_q     <= grant_q[1];
            last_grant_q <= grant_q[1];
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
`endif
          end
        end
        RESP: begin
          grant_q <= 2'b00;
`ifdef MEM_ARB_TIMEOUT_EN
          err_q   <= 1'b0;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign r0_ack       = r0_ack_q;
  assign r1_ack       = r1_ack_q;
  assign rdata        = rdata_q;
  assign mem_read_en  = rd_en_q;
  assign mem_write_en = wr_en_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign grant        = grant_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; with MEM_ARB_TIMEOUT_EN defined it also
// exercises the timeout path using TIMEOUT=8.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  localparam logic [127:0] LINE_A = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] LINE_B = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] LINE_C = 128'h0F0F0F0F_A5A5A5A5_5A5A5A5A_F0F0F0F0;
  localparam logic [127:0] LINE_D = 128'h00000000_FFFFFFFF_13579BDF_2468ACE0;

  logic         clk;
  logic         rst;
  logic         r0_req;
  logic         r0_we;
  logic [9:0]   r0_addr;
  logic [31:0]  r0_wdata;
  logic         r0_ack;
  logic         r1_req;
  logic         r1_we;
  logic [9:0]   r1_addr;
  logic [31:0]  r1_wdata;
  logic         r1_ack;
  logic [127:0] rdata;
  logic         err;
  logic         mem_read_en;
  logic         mem_write_en;
  logic [9:0]   mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_ready;
  logic [127:0] mem_rdata;
  logic [1:0]   grant;
  logic         busy;

  int passCount;
  int checkCount;
  int failCount;

  logic [1:0] tieGrant [4];

  mem_port_arbiter #(
    .ADDR_W (10),
    .WORD_W (32),
    .LINE_W (128),
    .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .r0_req      (r0_req),
    .r0_we       (r0_we),
    .r0_addr     (r0_addr),
    .r0_wdata    (r0_wdata),
    .r0_ack      (r0_ack),
    .r1_req      (r1_req),
    .r1_we       (r1_we),
    .r1_addr     (r1_addr),
    .r1_wdata    (r1_wdata),
    .r1_ack      (r1_ack),
    .rdata       (rdata),
    .err         (err),
    .mem_read_en (mem_read_en),
    .mem_write_en(mem_write_en),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .grant       (grant),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int who, input logic req, input logic we,
                               input logic [9:0] addr, input logic [31:0] wdata);
    if (who == 0) begin
      r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wdata;
    end else begin
      r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wdata;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    passCount = 0;
    checkCount = 0;
    failCount = 0;
    tieGrant[0] = 2'b10;
    tieGrant[1] = 2'b01;
    tieGrant[2] = 2'b10;
    tieGrant[3] = 2'b01;

    rst = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 10'h000, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 10'h000, 32'h0);
    mem_ready = 1'b0;
    mem_rdata = '0;
    #12;
    checkOutput("reset_rdata", rdata, 128'h0);
    checkOutput("reset_grant", {126'h0, grant}, 128'h0);
    checkOutput("reset_busy", {127'h0, busy}, 128'h0);
    checkOutput("reset_rd_en", {127'h0, mem_read_en}, 128'h0);
    checkOutput("reset_wr_en", {127'h0, mem_write_en}, 128'h0);
    checkOutput("reset_acks", {126'h0, r1_ack, r0_ack}, 128'h0);
    checkOutput("reset_err", {127'h0, err}, 128'h0);
    checkOutput("reset_mem_addr", {118'h0, mem_addr}, 128'h0);
    checkOutput("reset_mem_wdata", {96'h0, mem_wdata}, 128'h0);

    $display("[TB] single read from requester 0");
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 10'h040, 32'h0);
    tick();
    checkOutput("rd_en_rise", {127'h0, mem_read_en}, 128'h1);
    checkOutput("rd_wr_en_low", {127'h0, mem_write_en}, 128'h0);
    checkOutput("rd_addr", {118'h0, mem_addr}, 128'h040);
    checkOutput("rd_grant", {126'h0, grant}, 128'h1);
    checkOutput("rd_busy", {127'h0, busy}, 128'h1);
    repeat (3) begin
      tick();
      checkOutput("rd_en_held", {127'h0, mem_read_en}, 128'h1);
      checkOutput("rd_no_ack_yet", {126'h0, r1_ack, r0_ack}, 128'h0);
    end
    tick();
    mem_ready = 1'b1;
    mem_rdata = LINE_A;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    checkOutput("rd_acks", {126'h0, r1_ack, r0_ack}, 128'h1);
    checkOutput("rd_rdata", rdata, LINE_A);
    checkOutput("rd_en_dropped", {127'h0, mem_read_en}, 128'h0);
    checkOutput("rd_resp_grant", {126'h0, grant}, 128'h1);
    checkOutput("rd_err", {127'h0, err}, 128'h0);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 10'h000, 32'h0);
    checkOutput("rd_ack_pulse", {126'h0, r1_ack, r0_ack}, 128'h0);
    checkOutput("rd_idle_grant", {126'h0, grant}, 128'h0);
    checkOutput("rd_idle_busy", {127'h0, busy}, 128'h0);
    checkOutput("rd_rdata_hold", rdata, LINE_A);

    mem_ready = 1'b1;
    mem_rdata = LINE_B;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    checkOutput("idle_ready_busy", {127'h0, busy}, 128'h0);
    checkOutput("idle_ready_acks", {126'h0, r1_ack, r0_ack}, 128'h0);
    checkOutput("idle_ready_rdata", rdata, LINE_A);

    $display("[TB] single write from requester 1");
    applyStimulus(1, 1'b1, 1'b1, 10'h3FC, 32'h12345678);
    tick();
    checkOutput("wr_en_rise", {127'h0, mem_write_en}, 128'h1);
    checkOutput("wr_rd_en_low", {127'h0, mem_read_en}, 128'h0);
    checkOutput("wr_addr", {118'h0, mem_addr}, 128'h3FC);
    checkOutput("wr_wdata", {96'h0, mem_wdata}, 128'h12345678);
    checkOutput("wr_grant", {126'h0, grant}, 128'h2);
    tick();
    checkOutput("wr_en_held", {127'h0, mem_write_en}, 128'h1);
    checkOutput("wr_addr_held", {118'h0, mem_addr}, 128'h3FC);
    checkOutput("wr_wdata_held", {96'h0, mem_wdata}, 128'h12345678);
    checkOutput("wr_rd_en_still_low", {127'h0, mem_read_en}, 128'h0);
    mem_ready = 1'b1;
    mem_rdata = LINE_B;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    checkOutput("wr_acks", {126'h0, r1_ack, r0_ack}, 128'h2);
    checkOutput("wr_en_dropped", {127'h0, mem_write_en}, 128'h0);
    checkOutput("wr_resp_rd_en", {127'h0, mem_read_en}, 128'h0);
    tick();
    applyStimulus(1, 1'b0, 1'b0, 10'h000, 32'h0);
    checkOutput("wr_ack_pulse", {126'h0, r1_ack, r0_ack}, 128'h0);
    checkOutput("wr_idle_busy", {127'h0, busy}, 128'h0);

    $display("[TB] reset in the middle of an access");
    applyStimulus(0, 1'b1, 1'b0, 10'h080, 32'h0);
    tick();
    checkOutput("mid_rd_en", {127'h0, mem_read_en}, 128'h1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_rd_en", {127'h0, mem_read_en}, 128'h0);
    checkOutput("mid_rst_grant", {126'h0, grant}, 128'h0);
    checkOutput("mid_rst_busy", {127'h0, busy}, 128'h0);
    checkOutput("mid_rst_rdata", rdata, 128'h0);
    checkOutput("mid_rst_mem_addr", {118'h0, mem_addr}, 128'h0);
    tick();
    rst = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 10'h000, 32'h0);
    repeat (4) begin
      tick();
      checkOutput("post_rst_no_ack", {126'h0, r1_ack, r0_ack}, 128'h0);
      checkOutput("post_rst_busy", {127'h0, busy}, 128'h0);
    end

    $display("[TB] repeated ties after reset");
    applyStimulus(0, 1'b1, 1'b0, 10'h100, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 10'h200, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("tie_grant", {126'h0, grant}, {126'h0, tieGrant[i]});
      checkOutput("tie_addr", {118'h0, mem_addr},
                  (tieGrant[i] == 2'b10) ? 128'h200 : 128'h100);
      mem_ready = 1'b1;
      mem_rdata = LINE_C ^ 128'(i);
      tick();
      mem_ready = 1'b0;
      mem_rdata = '0;
      checkOutput("tie_acks", {126'h0, r1_ack, r0_ack}, {126'h0, tieGrant[i]});
      checkOutput("tie_rdata", rdata, LINE_C ^ 128'(i));
      tick();
      checkOutput("tie_idle_grant", {126'h0, grant}, 128'h0);
    end

    $display("[TB] back-to-back re-request from requester 0");
    tick();
    checkOutput("b2b_first_grant", {126'h0, grant}, 128'h2);
    checkOutput("b2b_first_addr", {118'h0, mem_addr}, 128'h200);
    mem_ready = 1'b1;
    mem_rdata = LINE_D;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    checkOutput("b2b_first_acks", {126'h0, r1_ack, r0_ack}, 128'h2);
    tick();
    applyStimulus(1, 1'b0, 1'b0, 10'h000, 32'h0);
    tick();
    checkOutput("b2b_second_grant", {126'h0, grant}, 128'h1);
    checkOutput("b2b_second_addr", {118'h0, mem_addr}, 128'h100);
    mem_ready = 1'b1;
    mem_rdata = LINE_B;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    checkOutput("b2b_second_acks", {126'h0, r1_ack, r0_ack}, 128'h1);
    checkOutput("b2b_second_rdata", rdata, LINE_B);
    checkOutput("b2b_err", {127'h0, err}, 128'h0);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 10'h000, 32'h0);

`ifdef MEM_ARB_TIMEOUT_EN
    $display("[TB] timeout with mem_ready held low");
    applyStimulus(0, 1'b1, 1'b0, 10'h0C0, 32'h0);
    tick();
    checkOutput("to_rd_en", {127'h0, mem_read_en}, 128'h1);
    repeat (7) begin
      tick();
      checkOutput("to_rd_en_held", {127'h0, mem_read_en}, 128'h1);
      checkOutput("to_no_ack_yet", {126'h0, r1_ack, r0_ack}, 128'h0);
    end
    tick();
    checkOutput("to_acks", {126'h0, r1_ack, r0_ack}, 128'h1);
    checkOutput("to_err", {127'h0, err}, 128'h1);
    checkOutput("to_rdata", rdata, 128'h0);
    checkOutput("to_rd_en_dropped", {127'h0, mem_read_en}, 128'h0);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 10'h000, 32'h0);
    checkOutput("to_err_cleared", {127'h0, err}, 128'h0);
    tick();
    applyStimulus(0, 1'b1, 1'b0, 10'h0C4, 32'h0);
    tick();
    mem_ready = 1'b1;
    mem_rdata = LINE_D;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    checkOutput("to_next_acks", {126'h0, r1_ack, r0_ack}, 128'h1);
    checkOutput("to_next_err", {127'h0, err}, 128'h0);
    checkOutput("to_next_rdata", rdata, LINE_D);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 10'h000, 32'h0);
`endif

    tick();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
